// File: rtl/vlsu_pkg.sv
// Shared VLSU types for the sequential store path.
// Holds the store FSM state encoding and the latched transaction bundle.
package vlsu_pkg;

    localparam int unsigned SstAxiDataWidth = 128;
    localparam int unsigned SstCntWidth     = 16;
    localparam int unsigned SstOffW         = $clog2(SstAxiDataWidth / 8);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        FLUSH
    } sst_state_e;

    typedef struct packed {
        logic [SstOffW-1:0]     off;
        logic [SstCntWidth-1:0] nbytes;
    } sst_txn_t;

endpackage

// File: rtl/store_realign.sv
// Combinational realigner: shifts a packed word to the bus offset, merges
// the carry, extracts the next carry and builds the W strobes.
// Ports: off/remaining/is_first/is_flush control, rx_data/carry in,
// data/carry_next/strb out.
module store_realign
    import vlsu_pkg::*;
#(
    parameter int unsigned AxiDataWidth = SstAxiDataWidth,
    parameter int unsigned CntWidth     = SstCntWidth,
    parameter int unsigned OffW         = $clog2(AxiDataWidth / 8)
) (
    input  logic [OffW-1:0]           off,
    input  logic [CntWidth-1:0]       remaining,
    input  logic                      is_first,
    input  logic                      is_flush,
    input  logic [AxiDataWidth-1:0]   rx_data,
    input  logic [AxiDataWidth-1:0]   carry,
    output logic [AxiDataWidth-1:0]   data,
    output logic [AxiDataWidth-1:0]   carry_next,
    output logic [AxiDataWidth/8-1:0] strb
);

    localparam int unsigned B  = AxiDataWidth / 8;
    localparam int unsigned SW = $clog2(AxiDataWidth) + 1;
    localparam int unsigned EW = CntWidth + 1;

    logic [SW-1:0] sh_up;
    logic [SW-1:0] sh_dn;
    logic [EW-1:0] end_w;

    always_comb begin
        sh_up = SW'({off, 3'b000});
        sh_dn = SW'(AxiDataWidth) - sh_up;
        // one past the last lane holding a valid byte of this beat
        end_w = EW'(off) + EW'(remaining);

        if (is_flush) begin
            data = carry;
        end else begin
            data = (rx_data << sh_up) | carry;
        end

        if (off == '0) begin
            carry_next = '0;
        end else begin
            carry_next = rx_data >> sh_dn;
        end

        strb = '0;
        for (int l = 0; l < B; l++) begin
            if (is_flush) begin
                // remaining carries nbytes here; end lane wraps mod B
                strb[l] = OffW'(l) < end_w[OffW-1:0];
            end else begin
                strb[l] = (EW'(l) < end_w) &&
                          (!is_first || (OffW'(l) >= off));
            end
        end
    end

endmodule

// File: rtl/sequential_store.sv
// Turns densely packed store bytes into offset-aligned AXI W beats.
// Ports: txn_* control handshake, rx_* packed data in, w_* AXI W beats out.
module sequential_store
    import vlsu_pkg::*;
#(
    parameter int unsigned AxiDataWidth = SstAxiDataWidth,
    parameter int unsigned CntWidth     = SstCntWidth,
    parameter int unsigned OffW         = $clog2(AxiDataWidth / 8)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      txn_valid_i,
    output logic                      txn_ready_o,
    input  logic [OffW-1:0]           txn_off_i,
    input  logic [CntWidth-1:0]       txn_nbytes_i,
    input  logic                      rx_valid_i,
    output logic                      rx_ready_o,
    input  logic [AxiDataWidth-1:0]   rx_data_i,
    output logic                      w_valid_o,
    input  logic                      w_ready_i,
    output logic [AxiDataWidth-1:0]   w_data_o,
    output logic [AxiDataWidth/8-1:0] w_strb_o,
    output logic                      w_last_o
);

    localparam int unsigned B  = AxiDataWidth / 8;
    localparam int unsigned EW = CntWidth + 1;

    sst_state_e                state_q;
    sst_txn_t                  txn_q;
    logic [CntWidth-1:0]       rem_q;
    logic                      first_q;
    logic [AxiDataWidth-1:0]   carry_q;
    logic                      w_valid_q;
    logic                      w_last_q;
    logic [AxiDataWidth-1:0]   w_data_q;
    logic [B-1:0]              w_strb_q;

    logic [OffW-1:0]           off;
    logic                      is_flush;
    logic [CntWidth-1:0]       rem_in;
    logic                      slot_free;
    logic                      rx_fire;
    logic                      last_word;
    logic                      fits;
    logic [CntWidth-1:0]       take;
    logic [AxiDataWidth-1:0]   ra_data;
    logic [AxiDataWidth-1:0]   ra_carry;
    logic [B-1:0]              ra_strb;

    assign off       = OffW'(txn_q.off);
    assign is_flush  = (state_q == FLUSH);
    assign rem_in    = is_flush ? CntWidth'(txn_q.nbytes) : rem_q;
    assign slot_free = !w_valid_q || w_ready_i;
    assign rx_fire   = (state_q == DATA) && slot_free && rx_valid_i;
    assign last_word = rem_q <= CntWidth'(B);
    assign fits      = (EW'(off) + EW'(rem_q)) <= EW'(B);
    assign take      = last_word ? rem_q : CntWidth'(B);

    assign txn_ready_o = (state_q == IDLE);
    assign rx_ready_o  = (state_q == DATA) && slot_free;
    assign w_valid_o   = w_valid_q;
    assign w_data_o    = w_data_q;
    assign w_strb_o    = w_strb_q;
    assign w_last_o    = w_last_q;

    store_realign #(
        .AxiDataWidth (AxiDataWidth),
        .CntWidth     (CntWidth),
        .OffW         (OffW)
    ) u_realign (
        .off        (off),
        .remaining  (rem_in),
        .is_first   (first_q),
        .is_flush   (is_flush),
        .rx_data    (rx_data_i),
        .carry      (carry_q),
        .data       (ra_data),
        .carry_next (ra_carry),
        .strb       (ra_strb)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            txn_q     <= '0;
            rem_q     <= '0;
            first_q   <= 1'b0;
            carry_q   <= '0;
            w_valid_q <= 1'b0;
            w_last_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
        end else begin
            // a load below overrides this drop in the same cycle
            if (w_valid_q && w_ready_i) begin
                w_valid_q <= 1'b0;
            end
            unique case (state_q)
                IDLE: begin
                    if (txn_valid_i) begin
                        txn_q.off    <= SstOffW'(txn_off_i);
                        txn_q.nbytes <= SstCntWidth'(txn_nbytes_i);
                        rem_q        <= txn_nbytes_i;
                        first_q      <= 1'b1;
                        carry_q      <= '0;
                        state_q      <= DATA;
                    end
                end
                DATA: begin
                    if (rx_fire) begin
                        w_valid_q <= 1'b1;
                        w_data_q  <= ra_data;
                        w_strb_q  <= ra_strb;
                        w_last_q  <= last_word && fits;
                        carry_q   <= ra_carry;
                        first_q   <= 1'b0;
                        rem_q     <= rem_q - take;
                        if (last_word) begin
                            state_q <= fits ? IDLE : FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (slot_free) begin
                        w_valid_q <= 1'b1;
                        w_data_q  <= ra_data;
                        w_strb_q  <= ra_strb;
                        w_last_q  <= 1'b1;
                        carry_q   <= '0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifndef SYNTHESIS
    a_nbytes_nonzero: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        (txn_valid_i && txn_ready_o) |-> (txn_nbytes_i != '0)
    );
`endif

endmodule

// File: tb/tb_sequential_store.sv
// Scoreboard bench for sequential_store (128-bit bus, 16 bytes per beat).
// Expected beats come from a byte-mapping model of the transaction.
module tb_sequential_store;

    localparam int B = 16;

    typedef struct {
        logic [127:0] data;
        logic [15:0]  strb;
        logic         last;
    } beat_t;

    logic         clk;
    logic         rst_ni;
    logic         txn_valid_i;
    logic         txn_ready_o;
    logic [3:0]   txn_off_i;
    logic [15:0]  txn_nbytes_i;
    logic         rx_valid_i;
    logic         rx_ready_o;
    logic [127:0] rx_data_i;
    logic         w_valid_o;
    logic         w_ready_i;
    logic [127:0] w_data_o;
    logic [15:0]  w_strb_o;
    logic         w_last_o;

    beat_t        sb[$];
    logic [7:0]   tb_bytes [0:1023];
    int           n_vec = 0;
    int           n_err = 0;

    logic         hold_v;
    logic [127:0] hold_d;
    logic [15:0]  hold_s;
    logic         hold_l;

    sequential_store dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .txn_valid_i  (txn_valid_i),
        .txn_ready_o  (txn_ready_o),
        .txn_off_i    (txn_off_i),
        .txn_nbytes_i (txn_nbytes_i),
        .rx_valid_i   (rx_valid_i),
        .rx_ready_o   (rx_ready_o),
        .rx_data_i    (rx_data_i),
        .w_valid_o    (w_valid_o),
        .w_ready_i    (w_ready_i),
        .w_data_o     (w_data_o),
        .w_strb_o     (w_strb_o),
        .w_last_o     (w_last_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_ni) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                chk("hold_valid", 128'(w_valid_o), 128'(1));
                chk("hold_data", w_data_o, hold_d);
                chk("hold_strb", 128'(w_strb_o), 128'(hold_s));
                chk("hold_last", 128'(w_last_o), 128'(hold_l));
            end
            if (w_valid_o && !w_ready_i)
                chk("rx_rdy_stall", 128'(rx_ready_o), 128'(0));
            if (w_valid_o && w_ready_i) begin
                if (sb.size() == 0) begin
                    chk("extra_beat", 128'(1), 128'(0));
                end else begin
                    beat_t e;
                    logic [127:0] mask;
                    e = sb.pop_front();
                    mask = '0;
                    for (int l = 0; l < B; l++)
                        if (e.strb[l]) mask[l*8 +: 8] = 8'hFF;
                    chk("beat_strb", 128'(w_strb_o), 128'(e.strb));
                    chk("beat_data", w_data_o & mask, e.data);
                    chk("beat_last", 128'(w_last_o), 128'(e.last));
                end
            end
            hold_v = w_valid_o && !w_ready_i;
            hold_d = w_data_o;
            hold_s = w_strb_o;
            hold_l = w_last_o;
        end
    end

    function automatic logic [127:0] word(input int k);
        logic [127:0] d;
        for (int l = 0; l < B; l++) d[l*8 +: 8] = tb_bytes[k*B + l];
        return d;
    endfunction

    task automatic fill(input int n, input bit pat);
        int words;
        words = (n + B - 1) / B;
        for (int i = 0; i < words * B; i++)
            tb_bytes[i] = pat ? 8'(i) : 8'($urandom);
    endtask

    task automatic push_exp(input int off, input int n);
        int beats;
        beats = (off + n + B - 1) / B;
        for (int j = 0; j < beats; j++) begin
            beat_t e;
            e.data = '0;
            e.strb = '0;
            for (int l = 0; l < B; l++) begin
                int i;
                i = j * B + l - off;
                if (i >= 0 && i < n) begin
                    e.data[l*8 +: 8] = tb_bytes[i];
                    e.strb[l] = 1'b1;
                end
            end
            e.last = (j == beats - 1);
            sb.push_back(e);
        end
    endtask

    task automatic drive_txn(input int off, input int n);
        bit hs;
        int t;
        txn_valid_i = 1'b1;
        txn_off_i = 4'(off);
        txn_nbytes_i = 16'(n);
        hs = 0;
        t = 0;
        while (!hs && t < 500) begin
            @(negedge clk);
            hs = txn_ready_o;
            @(posedge clk);
            #1;
            t++;
        end
        if (!hs) chk("txn_timeout", 128'(0), 128'(1));
        txn_valid_i = 1'b0;
    endtask

    task automatic send_word(input logic [127:0] d, input bit chk_busy);
        bit hs;
        int t;
        rx_valid_i = 1'b1;
        rx_data_i = d;
        hs = 0;
        t = 0;
        while (!hs && t < 500) begin
            @(negedge clk);
            hs = rx_ready_o;
            if (chk_busy && t == 0)
                chk("txn_rdy_busy", 128'(txn_ready_o), 128'(0));
            @(posedge clk);
            #1;
            t++;
        end
        if (!hs) chk("rx_timeout", 128'(0), 128'(1));
        rx_valid_i = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", 128'(sb.size()), 128'(0));
            sb.delete();
        end
        @(posedge clk);
        #1;
        chk("w_idle", 128'(w_valid_o), 128'(0));
        chk("txn_rdy_idle", 128'(txn_ready_o), 128'(1));
    endtask

    task automatic run_txn(input int off, input int n, input bit pat);
        int words;
        bit flush;
        words = (n + B - 1) / B;
        flush = (off + n - (words - 1) * B) > B;
        fill(n, pat);
        push_exp(off, n);
        drive_txn(off, n);
        for (int w = 0; w < words; w++) send_word(word(w), w == 0);
        @(negedge clk);
        chk("lat_valid", 128'(w_valid_o), 128'(1));
        chk("flush_state", 128'(txn_ready_o), 128'(!flush));
        drain();
    endtask

    initial begin
        rst_ni = 1'b0;
        txn_valid_i = 1'b0;
        txn_off_i = '0;
        txn_nbytes_i = '0;
        rx_valid_i = 1'b0;
        rx_data_i = '0;
        w_ready_i = 1'b1;
        hold_v = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_txn_rdy", 128'(txn_ready_o), 128'(1));
        chk("rst_rx_rdy", 128'(rx_ready_o), 128'(0));
        chk("rst_w_valid", 128'(w_valid_o), 128'(0));
        chk("rst_w_last", 128'(w_last_o), 128'(0));
        chk("rst_w_data", w_data_o, 128'(0));
        chk("rst_w_strb", 128'(w_strb_o), 128'(0));
        rst_ni = 1'b1;
        @(posedge clk);
        #1;

        run_txn(0, 32, 1'b0);
        run_txn(4, 16, 1'b1);
        run_txn(3, 5, 1'b0);

        fork
            run_txn(0, 32, 1'b0);
            begin
                repeat (2) @(posedge clk);
                #1;
                w_ready_i = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                w_ready_i = 1'b1;
            end
        join

        run_txn(15, 2, 1'b0);
        run_txn(0, 1, 1'b0);
        run_txn(4, 40, 1'b0);

        fill(32, 1'b0);
        push_exp(0, 32);
        drive_txn(0, 32);
        send_word(word(0), 1'b1);
        send_word(word(1), 1'b0);
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_valid", 128'(w_valid_o), 128'(0));
        chk("mid_rst_last", 128'(w_last_o), 128'(0));
        chk("mid_rst_strb", 128'(w_strb_o), 128'(0));
        chk("mid_rst_data", w_data_o, 128'(0));
        chk("mid_rst_txn_rdy", 128'(txn_ready_o), 128'(1));
        chk("mid_rst_rx_rdy", 128'(rx_ready_o), 128'(0));
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
        run_txn(5, 20, 1'b0);

        for (int k = 0; k < 10; k++)
            run_txn($urandom_range(0, 15), $urandom_range(1, 60), 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
